// File: rtl/ttl_pattern_gen.sv
// ttl_pattern_gen: CH_NUM independent TTL pulse channels with delay, width, period and burst count.
// Optional loopback checker on RX is built only when PATGEN_LOOPBACK_CHK_EN is defined.
module ttl_pattern_gen #(
   parameter int CH_NUM  = 8,
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8,
   parameter int LB_DLY  = 4
) (
   input  logic              CLK_40M,
   input  logic              RST,
   input  logic              CFG_WE,
   input  logic [3:0]        CFG_CH,
   input  logic [1:0]        CFG_ADDR,
   input  logic [CNT_W-1:0]  CFG_DATA,
   input  logic              START,
   input  logic              STOP,
   output logic [CH_NUM-1:0] OUT,
   output logic [CH_NUM-1:0] BUSY,
   output logic              DONE,
   input  logic [CH_NUM-1:0] RX,
   output logic [15:0]       ERR_CNT
);

   typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_HIGH, ST_LOW} state_t;

   // shadow registers written by the config port
   logic [CNT_W-1:0]   per_sh_q [CH_NUM];
   logic [CNT_W-1:0]   per_sh_d [CH_NUM];
   logic [CNT_W-1:0]   wid_sh_q [CH_NUM];
   logic [CNT_W-1:0]   wid_sh_d [CH_NUM];
   logic [CNT_W-1:0]   dly_sh_q [CH_NUM];
   logic [CNT_W-1:0]   dly_sh_d [CH_NUM];
   logic [BURST_W-1:0] bur_sh_q [CH_NUM];
   logic [BURST_W-1:0] bur_sh_d [CH_NUM];

   // active copies captured on START
   logic [CNT_W-1:0]   per_q  [CH_NUM];
   logic [CNT_W-1:0]   per_d  [CH_NUM];
   logic [CNT_W-1:0]   wid_q  [CH_NUM];
   logic [CNT_W-1:0]   wid_d  [CH_NUM];
   logic [BURST_W-1:0] bur_q  [CH_NUM];
   logic [BURST_W-1:0] bur_d  [CH_NUM];
   logic [BURST_W-1:0] brem_q [CH_NUM];
   logic [BURST_W-1:0] brem_d [CH_NUM];
   logic [CNT_W-1:0]   cnt_q  [CH_NUM];
   logic [CNT_W-1:0]   cnt_d  [CH_NUM];
   state_t             state_q [CH_NUM];
   state_t             state_d [CH_NUM];

   logic [CH_NUM-1:0]  out_q, out_d;
   logic [CH_NUM-1:0]  busy_q, busy_d;
   logic               done_q, done_d;

   function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] p,
                                                    input logic [CNT_W-1:0] w);
      if (w >= p) return p - CNT_W'(1);
      return w;
   endfunction

   // A zero width skips HIGH and spends the whole period in LOW.
   function automatic state_t period_state(input logic [CNT_W-1:0] w);
      return (w != '0) ? ST_HIGH : ST_LOW;
   endfunction

   // cnt holds the number of cycles left after the current one in the state.
   function automatic logic [CNT_W-1:0] period_cnt(input logic [CNT_W-1:0] p,
                                                   input logic [CNT_W-1:0] w);
      return (w != '0) ? (w - CNT_W'(1)) : (p - CNT_W'(1));
   endfunction

   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         per_sh_d[i] = per_sh_q[i];
         wid_sh_d[i] = wid_sh_q[i];
         dly_sh_d[i] = dly_sh_q[i];
         bur_sh_d[i] = bur_sh_q[i];
         per_d[i]    = per_q[i];
         wid_d[i]    = wid_q[i];
         bur_d[i]    = bur_q[i];
         brem_d[i]   = brem_q[i];
         cnt_d[i]    = cnt_q[i];
         state_d[i]  = state_q[i];

         if (CFG_WE && (int'(CFG_CH) == i)) begin
            case (CFG_ADDR)
               2'd0:    per_sh_d[i] = CFG_DATA;
               2'd1:    wid_sh_d[i] = CFG_DATA;
               2'd2:    bur_sh_d[i] = CFG_DATA[BURST_W-1:0];
               default: dly_sh_d[i] = CFG_DATA;
            endcase
         end

         if (STOP) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
            brem_d[i]  = '0;
         end else if (START) begin
            per_d[i]  = per_sh_q[i];
            wid_d[i]  = clamp_width(per_sh_q[i], wid_sh_q[i]);
            bur_d[i]  = bur_sh_q[i];
            brem_d[i] = bur_sh_q[i];
            if (per_sh_q[i] == '0) begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end else if (dly_sh_q[i] != '0) begin
               state_d[i] = ST_DELAY;
               cnt_d[i]   = dly_sh_q[i] - CNT_W'(1);
            end else begin
               state_d[i] = period_state(wid_d[i]);
               cnt_d[i]   = period_cnt(per_sh_q[i], wid_d[i]);
            end
         end else begin
            case (state_q[i])
               ST_DELAY: begin
                  if (cnt_q[i] == '0) begin
                     state_d[i] = period_state(wid_q[i]);
                     cnt_d[i]   = period_cnt(per_q[i], wid_q[i]);
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
               ST_HIGH: begin
                  if (cnt_q[i] == '0) begin
                     state_d[i] = ST_LOW;
                     cnt_d[i]   = per_q[i] - wid_q[i] - CNT_W'(1);
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
               ST_LOW: begin
                  if (cnt_q[i] == '0) begin
                     // end of a period: finish the burst or start the next pulse
                     if ((bur_q[i] != '0) && (brem_q[i] == BURST_W'(1))) begin
                        state_d[i] = ST_IDLE;
                        brem_d[i]  = '0;
                     end else begin
                        if (bur_q[i] != '0) brem_d[i] = brem_q[i] - BURST_W'(1);
                        state_d[i] = period_state(wid_q[i]);
                        cnt_d[i]   = period_cnt(per_q[i], wid_q[i]);
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end

         out_d[i]  = (state_d[i] == ST_HIGH);
         busy_d[i] = (state_d[i] != ST_IDLE);
      end

      // Only natural burst completion may raise DONE; STOP or START emptying BUSY does not.
      done_d = (|busy_q) && !(|busy_d) && !STOP && !START;
   end

   always_ff @(posedge CLK_40M or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < CH_NUM; i++) begin
            per_sh_q[i] <= '0;
            wid_sh_q[i] <= '0;
            dly_sh_q[i] <= '0;
            bur_sh_q[i] <= '0;
            per_q[i]    <= '0;
            wid_q[i]    <= '0;
            bur_q[i]    <= '0;
            brem_q[i]   <= '0;
            cnt_q[i]    <= '0;
            state_q[i]  <= ST_IDLE;
         end
         out_q  <= '0;
         busy_q <= '0;
         done_q <= 1'b0;
      end else begin
         per_sh_q <= per_sh_d;
         wid_sh_q <= wid_sh_d;
         dly_sh_q <= dly_sh_d;
         bur_sh_q <= bur_sh_d;
         per_q    <= per_d;
         wid_q    <= wid_d;
         bur_q    <= bur_d;
         brem_q   <= brem_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign OUT  = out_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

`ifdef PATGEN_LOOPBACK_CHK_EN
   logic [CH_NUM-1:0] pipe_q [LB_DLY];
   logic [CH_NUM-1:0] pipe_d [LB_DLY];
   logic [CH_NUM-1:0] mis;
   logic [15:0]       err_q, err_d;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {12'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [4:0] popcnt(input logic [CH_NUM-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < CH_NUM; i++) n = n + 5'(v[i]);
      return n;
   endfunction

   // pipe_q[LB_DLY-1] holds OUT as it was LB_DLY cycles ago
   always_comb begin
      pipe_d[0] = out_q;
      for (int k = 1; k < LB_DLY; k++) pipe_d[k] = pipe_q[k-1];
      mis   = (RX ^ pipe_q[LB_DLY-1]) & busy_q;
      err_d = START ? 16'h0000 : sat_add(err_q, popcnt(mis));
   end

   always_ff @(posedge CLK_40M or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < LB_DLY; k++) pipe_q[k] <= '0;
         err_q <= '0;
      end else begin
         pipe_q <= pipe_d;
         err_q  <= err_d;
      end
   end

   assign ERR_CNT = err_q;
`else
   localparam int LB_DLY_UNUSED = LB_DLY;
   logic rx_unused;
   assign rx_unused = ^RX;
   assign ERR_CNT   = 16'h0000;
`endif

endmodule

// File: tb/tb_ttl_pattern_gen.sv
// Directed bench for ttl_pattern_gen: a per-channel timing model computed from start cycle
// and period arithmetic, checked every cycle, plus literal expectations for key scenarios.
`timescale 1ns/100ps
module tb_ttl_pattern_gen;
   localparam int CH = 8;
   localparam int CW = 16;
   localparam int BW = 8;
   localparam int LB = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we, start, stop;
   logic [3:0]    cfg_ch;
   logic [1:0]    cfg_addr;
   logic [CW-1:0] cfg_data;
   logic [CH-1:0] out_w, busy_w, rx;
   logic          done_w;
   logic [15:0]   err_w;

   ttl_pattern_gen #(.CH_NUM(CH), .CNT_W(CW), .BURST_W(BW), .LB_DLY(LB)) dut (
      .CLK_40M(clk), .RST(rst), .CFG_WE(cfg_we), .CFG_CH(cfg_ch), .CFG_ADDR(cfg_addr),
      .CFG_DATA(cfg_data), .START(start), .STOP(stop), .OUT(out_w), .BUSY(busy_w),
      .DONE(done_w), .RX(rx), .ERR_CNT(err_w)
   );

   initial forever #12.5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   // loopback source: either zero or the DUT's own OUT delayed by LB cycles
   bit            rx_mode = 1'b0;
   logic [CH-1:0] rx_pipe [LB];
   always @(posedge clk) begin
      rx_pipe[0] <= out_w;
      for (int k = 1; k < LB; k++) rx_pipe[k] <= rx_pipe[k-1];
   end
   assign rx = rx_mode ? rx_pipe[LB-1] : '0;

   // behavioural model state
   int unsigned sh_p [CH], sh_w [CH], sh_b [CH], sh_d [CH];
   bit          run_on [CH];
   int unsigned r_p [CH], r_w [CH], r_b [CH], r_d [CH];
   int          r_s [CH];
   bit          ctrl_edge;
   bit [CH-1:0] prev_busy, cur_busy;
   bit [CH-1:0] hist [8];
   int unsigned err_m = 0;

   function automatic void model_ch(input int i, input int c, output bit b, output bit o);
      int k;
      int n;
      b = 1'b0;
      o = 1'b0;
      if (!run_on[i] || c < r_s[i]) return;
      k = c - r_s[i];
      if (k < int'(r_d[i])) begin
         b = 1'b1;
         return;
      end
      k = k - int'(r_d[i]);
      n = k / int'(r_p[i]);
      if (r_b[i] != 0 && n >= int'(r_b[i])) return;
      b = 1'b1;
      o = (k % int'(r_p[i])) < int'(r_w[i]);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            sh_p[i] = 0; sh_w[i] = 0; sh_b[i] = 0; sh_d[i] = 0;
            run_on[i] = 1'b0;
         end
         for (int h = 0; h < 8; h++) hist[h] = '0;
         err_m     = 0;
         ctrl_edge = 1'b1;
      end else begin
`ifdef PATGEN_LOOPBACK_CHK_EN
         if (start) err_m = 0;
         else begin
            for (int i = 0; i < CH; i++)
               if (cur_busy[i] && (rx[i] !== hist[(cyc - LB) & 7][i]))
                  err_m = (err_m >= 65535) ? 65535 : err_m + 1;
         end
`endif
         ctrl_edge = start | stop;
         if (stop) begin
            for (int i = 0; i < CH; i++) run_on[i] = 1'b0;
         end else if (start) begin
            for (int i = 0; i < CH; i++) begin
               run_on[i] = (sh_p[i] != 0);
               r_p[i] = sh_p[i];
               r_w[i] = (sh_w[i] >= sh_p[i]) ? sh_p[i] - 1 : sh_w[i];
               r_b[i] = sh_b[i];
               r_d[i] = sh_d[i];
               r_s[i] = cyc + 1;
            end
         end
         if (cfg_we && cfg_ch < CH) begin
            case (cfg_addr)
               2'd0: sh_p[cfg_ch] = cfg_data;
               2'd1: sh_w[cfg_ch] = cfg_data;
               2'd2: sh_b[cfg_ch] = cfg_data & 16'h00FF;
               default: sh_d[cfg_ch] = cfg_data;
            endcase
         end
      end
   end

   bit [CH-1:0] eo, eb;
   bit          mb, mo, ed;
   always @(negedge clk) begin
      for (int i = 0; i < CH; i++) begin
         model_ch(i, cyc, mb, mo);
         eb[i] = mb;
         eo[i] = mo;
      end
      ed = (|prev_busy) && (eb == '0) && !ctrl_edge;
      chk("m_OUT", out_w, eo);
      chk("m_BUSY", busy_w, eb);
      chk("m_DONE", done_w, ed);
      chk("m_ERR_CNT", err_w, err_m);
      hist[cyc & 7] = eo;
      prev_busy     = eb;
      cur_busy      = eb;
   end

   task automatic cfg(input int ch, input int a, input int d);
      cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_addr = 2'(a); cfg_data = 16'(d);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycle %0d: got timeout, want finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = 0; start = 0; stop = 0;
      repeat (3) @(negedge clk);
      chk("rst_OUT", out_w, 0);
      chk("rst_BUSY", busy_w, 0);
      chk("rst_DONE", done_w, 0);
      chk("rst_ERR", err_w, 0);
      rst = 1'b0;
      @(negedge clk);

      // two-pulse burst on ch0
      cfg(0, 0, 10); cfg(0, 1, 3); cfg(0, 2, 2); cfg(0, 3, 0);
      pulse_start();
      for (int k = 1; k <= 23; k++) begin
         chk("b_OUT0", out_w[0], (k <= 3) || (k >= 11 && k <= 13));
         chk("b_BUSY0", busy_w[0], k <= 20);
         chk("b_DONE", done_w, k == 21);
         @(negedge clk);
      end

      // clamped width on ch1, delayed continuous ch2, then STOP
      cfg(1, 0, 5); cfg(1, 1, 7); cfg(2, 0, 7); cfg(2, 1, 2); cfg(2, 3, 3);
      pulse_start();
      for (int k = 1; k <= 12; k++) begin
         chk("c_OUT1", out_w[1], ((k - 1) % 5) < 4);
         chk("c_OUT2", out_w[2], (k >= 4) && (((k - 4) % 7) < 2));
         chk("c_BUSY2", busy_w[2], 1);
         @(negedge clk);
      end
      pulse_stop();
      chk("s_OUT", out_w, 0);
      chk("s_BUSY", busy_w, 0);
      chk("s_DONE", done_w, 0);
      repeat (5) @(negedge clk);

      // START and STOP together while idle
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      chk("ss_BUSY", busy_w, 0);
      repeat (3) @(negedge clk);

      // zero-width ch3, shadow isolation on ch0 during a run
      cfg(1, 0, 0); cfg(2, 0, 0);
      cfg(3, 0, 4); cfg(3, 1, 0); cfg(3, 2, 2);
      pulse_start();
      cfg(0, 1, 5);
      for (int k = 2; k <= 24; k++) begin
         chk("z_OUT0", out_w[0], (k <= 3) || (k >= 11 && k <= 13));
         chk("z_OUT3", out_w[3], 0);
         chk("z_DONE", done_w, k == 21);
         @(negedge clk);
      end

      // out-of-range channel writes, then restart while busy
      cfg(8, 1, 1); cfg(15, 0, 3);
      pulse_start();
      repeat (3) @(negedge clk);
      pulse_start();
      for (int k = 1; k <= 7; k++) begin
         chk("r_OUT0", out_w[0], k <= 5);
         chk("r_BUSY0", busy_w[0], 1);
         @(negedge clk);
      end
      repeat (25) @(negedge clk);

      // maximum period with clamped width
      cfg(4, 0, 65535); cfg(4, 1, 65535);
      pulse_start();
      repeat (20) @(negedge clk);
      chk("x_OUT4", out_w[4], 1);
      pulse_stop();
      cfg(4, 0, 0); cfg(3, 0, 0);
      repeat (3) @(negedge clk);

      // asynchronous reset in the middle of HIGH
      pulse_start();
      @(negedge clk);
      chk("a_OUT0_pre", out_w[0], 1);
      #2 rst = 1'b1;
      #1;
      chk("a_OUT_async", out_w, 0);
      chk("a_BUSY_async", busy_w, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      pulse_start();
      chk("a_BUSY_after", busy_w, 0);
      repeat (3) @(negedge clk);

      // loopback: matching echo, then RX tied low on a single pulse
      cfg(0, 0, 10); cfg(0, 1, 3); cfg(0, 2, 2);
      rx_mode = 1'b1;
      pulse_start();
      repeat (30) @(negedge clk);
      chk("l_ERR_echo", err_w, 0);
      rx_mode = 1'b0;
      cfg(0, 2, 1);
      pulse_start();
      repeat (20) @(negedge clk);
`ifdef PATGEN_LOOPBACK_CHK_EN
      chk("l_ERR_tied", err_w, 3);
`else
      chk("l_ERR_tied", err_w, 0);
`endif
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ttl_pattern_gen.md
TTL_PATTERN_GEN -- requirements
Module: ttl_pattern_gen

Interface
REQ-001 Parameter CH_NUM, default 8, number of independent output channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of the period, width and delay counters.
REQ-003 Parameter BURST_W, default 8, width of the burst pulse counter.
REQ-004 Parameter LB_DLY, default 4, expected loopback latency in clocks (1..15).
REQ-005 CLK_40M  input  1  sole clock, 40 MHz.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 CFG_WE  input  1  config write strobe, one cycle.
REQ-008 CFG_CH  input  4  channel index; writes with CFG_CH >= CH_NUM are ignored.
REQ-009 CFG_ADDR  input  2  register select: 0 period, 1 width, 2 burst, 3 delay.
REQ-010 CFG_DATA  input  CNT_W  write data; burst uses the low BURST_W bits.
REQ-011 START  input  1  one-cycle pulse; arms all channels with period != 0.
REQ-012 STOP  input  1  one-cycle pulse; aborts all channels.
REQ-013 OUT  output  CH_NUM  registered pulse outputs.
REQ-014 BUSY  output  CH_NUM  per-channel active flag.
REQ-015 DONE  output  1  one-cycle pulse when the last busy channel finishes a burst.
REQ-016 RX  input  CH_NUM  looped-back receive vector.
REQ-017 ERR_CNT  output  16  loopback mismatch count.

Function
REQ-018 Per channel, the FSM SHALL have states IDLE, DELAY, HIGH and LOW.
REQ-019 Config writes SHALL land in shadow registers; active counters SHALL load the shadows only on START.
REQ-020 On START at cycle t, each channel with period P != 0 SHALL leave IDLE at t+1; a channel with P = 0 SHALL stay IDLE.
REQ-021 A channel with delay D SHALL drive OUT high from cycle t+1+D.
REQ-022 HIGH SHALL last W cycles and LOW SHALL last P-W cycles, giving an exact period of P clocks.
REQ-023 A width W >= P SHALL be clamped to P-1 as a duty safety limit.
REQ-024 W = 0 SHALL keep OUT low while the period still counts.
REQ-025 Burst B != 0 SHALL emit exactly B pulses, then enter IDLE at the end of the last LOW; B = 0 SHALL run continuously.
REQ-026 BUSY[i] SHALL be 1 in every state except IDLE.
REQ-027 DONE SHALL pulse in the cycle that the BUSY vector goes from nonzero to zero through burst completion; STOP SHALL NOT raise DONE.
REQ-028 STOP SHALL force all OUT and BUSY bits to 0 and all channels to IDLE on the next edge.
REQ-029 When START and STOP coincide, STOP SHALL win.
REQ-030 START while busy SHALL restart every channel from DELAY with fresh shadow values.
REQ-031 Counters SHALL never wrap; P = 2^CNT_W-1 SHALL be a legal period.

Reset
REQ-032 Asserting RST SHALL immediately clear OUT, BUSY, DONE, ERR_CNT, all counters and all shadows, and set every channel to IDLE.
REQ-033 Deasserting RST mid-burst SHALL leave all channels IDLE until the next START.

Configuration
REQ-034 With macro PATGEN_LOOPBACK_CHK_EN defined, RX[i] SHALL be compared with OUT[i] delayed by LB_DLY clocks while BUSY[i] is set.
REQ-035 With the macro defined, each mismatching bit-cycle SHALL increment ERR_CNT, saturating at 0xFFFF, and START SHALL clear ERR_CNT.
REQ-036 Without the macro, RX SHALL be ignored and ERR_CNT SHALL be constant 0.

Verification
REQ-037 ch0 P=10, W=3, B=2, D=0; START at t -> OUT[0] high during t+1..t+3 and t+11..t+13; BUSY[0] falls and DONE pulses at t+21.
REQ-038 ch1 P=5, W=7 -> clamped W=4; OUT[1] high for 4 cycles and low for 1, repeating.
REQ-039 ch2 B=0, running; STOP at s -> OUT=0, BUSY=0 at s+1; no DONE.
REQ-040 START and STOP in the same cycle while idle -> BUSY stays 0.
REQ-041 Macro on, RX = OUT delayed by 4 -> ERR_CNT=0; RX tied 0 with ch0 P=10, W=3, B=1 -> ERR_CNT=3.
REQ-042 RST asserted mid-HIGH -> OUT=0 asynchronously; after release, no pulse appears until START.
